// File: rtl/timer_seq_ctrl.sv
// Avalon-MM master for a 16-bit interval timer: turns start/stop/snapshot requests
// into register write/read sequences and services the timeout IRQ.
module timer_seq_ctrl #(
   parameter int          AUTO_START     = 0,
   parameter logic [31:0] DEFAULT_PERIOD = 32'h02FA_F07F,
   parameter int          TICK_W         = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_start_req,
   input  logic              i_stop_req,
   input  logic              i_snap_req,
   input  logic [31:0]       i_cfg_period,
   input  logic              i_cfg_continuous,
   output logic              o_busy,
   output logic              o_running,
   output logic              o_tick,
   output logic [TICK_W-1:0] o_tick_count,
   output logic [31:0]       o_snap_value,
   output logic              o_snap_valid,
   output logic [2:0]        o_m_address,
   output logic              o_m_chipselect,
   output logic              o_m_write_n,
   output logic [15:0]       o_m_writedata,
   input  logic [15:0]       i_m_readdata,
   input  logic              i_timer_irq,
   output logic [3:0]        o_dbg_state
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      CLR_ST = 4'd1,
      ST_PL  = 4'd2,
      ST_PH  = 4'd3,
      ST_CTL = 4'd4,
      SP_CTL = 4'd5,
      SN_WR  = 4'd6,
      SN_RL  = 4'd7,
      SN_RH  = 4'd8,
      SN_DN  = 4'd9
   } state_t;

   localparam bit AUTO_EN = (AUTO_START != 0);

   state_t            r_state;
   state_t            w_next;
   logic              r_start_p;
   logic              r_stop_p;
   logic              r_snap_p;
   logic              r_boot;
   logic [31:0]       r_per_q;
   logic              r_cont_q;
   logic              r_running;
   logic              r_tick;
   logic [TICK_W-1:0] r_tick_count;
   logic [31:0]       r_snap_value;
   logic              r_snap_valid;
   logic [2:0]        r_m_address;
   logic              r_m_chipselect;
   logic              r_m_write_n;
   logic [15:0]       r_m_writedata;

   logic              w_auto;
   logic              w_start_acc;
   logic              w_enter_start;
   logic              w_enter_stop;
   logic              w_enter_snap;
   logic [2:0]        w_m_address;
   logic              w_m_chipselect;
   logic              w_m_write_n;
   logic [15:0]       w_m_writedata;

   // The boot start behaves like a start_req on the first cycle after reset release.
   assign w_auto      = AUTO_EN & ~r_boot;
   assign w_start_acc = (i_start_req | w_auto) & ~i_stop_req;

   assign w_enter_start = (r_state == IDLE) && (w_next == ST_PL);
   assign w_enter_stop  = (r_state == IDLE) && (w_next == SP_CTL);
   assign w_enter_snap  = (r_state == IDLE) && (w_next == SN_WR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Bus signals are decoded from the next state so each registered access lines up with its state cycle.
   always_comb begin
      w_next         = r_state;
      w_m_address    = 3'd0;
      w_m_chipselect = 1'b0;
      w_m_write_n    = 1'b1;
      w_m_writedata  = 16'h0000;
      case (r_state)
         IDLE: begin
            if (i_timer_irq)    w_next = CLR_ST;
            else if (r_stop_p)  w_next = SP_CTL;
            else if (r_start_p) w_next = ST_PL;
            else if (r_snap_p)  w_next = SN_WR;
         end
         CLR_ST:  w_next = IDLE;
         ST_PL:   w_next = ST_PH;
         ST_PH:   w_next = ST_CTL;
         ST_CTL:  w_next = IDLE;
         SP_CTL:  w_next = IDLE;
         SN_WR:   w_next = SN_RL;
         SN_RL:   w_next = SN_RH;
         SN_RH:   w_next = SN_DN;
         SN_DN:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
      case (w_next)
         CLR_ST: begin
            w_m_chipselect = 1'b1;
            w_m_write_n    = 1'b0;
            w_m_address    = 3'd0;
         end
         ST_PL: begin
            w_m_chipselect = 1'b1;
            w_m_write_n    = 1'b0;
            w_m_address    = 3'd2;
            w_m_writedata  = r_per_q[15:0];
         end
         ST_PH: begin
            w_m_chipselect = 1'b1;
            w_m_write_n    = 1'b0;
            w_m_address    = 3'd3;
            w_m_writedata  = r_per_q[31:16];
         end
         ST_CTL: begin
            w_m_chipselect = 1'b1;
            w_m_write_n    = 1'b0;
            w_m_address    = 3'd1;
            w_m_writedata  = {12'b0, 1'b0, 1'b1, r_cont_q, 1'b1};
         end
         SP_CTL: begin
            w_m_chipselect = 1'b1;
            w_m_write_n    = 1'b0;
            w_m_address    = 3'd1;
            w_m_writedata  = 16'h0008;
         end
         SN_WR: begin
            w_m_chipselect = 1'b1;
            w_m_write_n    = 1'b0;
            w_m_address    = 3'd4;
         end
         SN_RL: begin
            w_m_chipselect = 1'b1;
            w_m_address    = 3'd4;
         end
         SN_RH: begin
            w_m_chipselect = 1'b1;
            w_m_address    = 3'd5;
         end
         default: begin
            w_m_chipselect = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_start_p      <= 1'b0;
         r_stop_p       <= 1'b0;
         r_snap_p       <= 1'b0;
         r_boot         <= 1'b0;
         r_per_q        <= 32'h0;
         r_cont_q       <= 1'b0;
         r_running      <= 1'b0;
         r_tick         <= 1'b0;
         r_tick_count   <= '0;
         r_snap_value   <= 32'h0;
         r_snap_valid   <= 1'b0;
         r_m_address    <= 3'd0;
         r_m_chipselect <= 1'b0;
         r_m_write_n    <= 1'b1;
         r_m_writedata  <= 16'h0000;
      end else begin
         r_boot <= 1'b1;
         // A stop pulse also discards any start that has not been entered yet.
         r_start_p <= w_start_acc | (r_start_p & ~w_enter_start & ~i_stop_req);
         r_stop_p  <= i_stop_req | (r_stop_p & ~w_enter_stop);
         r_snap_p  <= i_snap_req | (r_snap_p & ~w_enter_snap);
         if (w_start_acc) begin
            r_per_q  <= i_start_req ? i_cfg_period : DEFAULT_PERIOD;
            r_cont_q <= i_start_req ? i_cfg_continuous : 1'b1;
         end
         if (r_state == ST_CTL) begin
            r_running <= 1'b1;
         end else if (r_state == SP_CTL) begin
            r_running <= 1'b0;
         end
         r_tick <= (w_next == CLR_ST);
         if (w_next == CLR_ST) begin
            r_tick_count <= r_tick_count + 1'b1;
         end
         // Read latency 1: the addr4 data arrives during SN_RH, the addr5 data during SN_DN.
         if (r_state == SN_RH) begin
            r_snap_value[15:0] <= i_m_readdata;
         end
         if (r_state == SN_DN) begin
            r_snap_value[31:16] <= i_m_readdata;
         end
         r_snap_valid   <= (r_state == SN_DN);
         r_m_address    <= w_m_address;
         r_m_chipselect <= w_m_chipselect;
         r_m_write_n    <= w_m_write_n;
         r_m_writedata  <= w_m_writedata;
      end
   end

   assign o_busy         = (r_state != IDLE) | r_start_p | r_stop_p | r_snap_p;
   assign o_running      = r_running;
   assign o_tick         = r_tick;
   assign o_tick_count   = r_tick_count;
   assign o_snap_value   = r_snap_value;
   assign o_snap_valid   = r_snap_valid;
   assign o_m_address    = r_m_address;
   assign o_m_chipselect = r_m_chipselect;
   assign o_m_write_n    = r_m_write_n;
   assign o_m_writedata  = r_m_writedata;
   assign o_dbg_state    = r_state;

endmodule

// File: doc/timer_seq_ctrl.md
Name: timer_seq_ctrl

Overview:
- Avalon-MM master that owns one 16-bit interval-timer slave: 6 registers, address 0..5, read latency 1, no waitrequest.
- Turns start/stop/snapshot requests from local logic into register write/read sequences.
- Services the timer IRQ by clearing the status register and counting timeouts.
- Sits between the application FSM and the timer, so software and the datapath never touch timer registers directly.

Parameters:
- AUTO_START, 0: 1 = launch a start sequence with DEFAULT_PERIOD immediately after reset.
- DEFAULT_PERIOD, 32'h02FAF07F: period used by AUTO_START.
- TICK_W, 16: width of tick_count.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- start_req  in  1  pulse; start the timer with cfg_period and cfg_continuous
- stop_req  in  1  pulse; stop the timer
- snap_req  in  1  pulse; capture and read the counter snapshot
- cfg_period  in  32  period value, sampled when a start is accepted
- cfg_continuous  in  1  continuous mode, sampled with cfg_period
- busy  out  1  FSM not in IDLE, or any request pending
- running  out  1  timer was started and not yet stopped
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  TICK_W  serviced timeouts; wraps modulo 2^TICK_W
- snap_value  out  32  last snapshot, {high word, low word}
- snap_valid  out  1  one-cycle pulse when snap_value updates
- m_address  out  3  timer register address
- m_chipselect  out  1  timer chipselect
- m_write_n  out  1  write strobe, active-low
- m_writedata  out  16  write data
- m_readdata  in  16  read data, valid the cycle after the address is driven
- timer_irq  in  1  level IRQ from the timer

Behaviour:
- Reset values:
  - FSM = IDLE; all pending flags 0.
  - m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
  - busy=0, running=0, tick=0, tick_count=0, snap_value=0, snap_valid=0.
- All master outputs are registered from state. Exactly one bus access per state cycle.
- Requests:
  - A request pulse sets its pending flag (start_p, stop_p, snap_p) in any state; a flag clears when its sequence is entered.
  - On a start accept, cfg_period and cfg_continuous are latched into per_q and cont_q.
  - stop_req clears a not-yet-entered start_p.
  - start_req and stop_req in the same cycle: stop wins, start is dropped.
- IDLE priority, evaluated every cycle: timer_irq > stop_p > start_p > snap_p.
- States and bus cycles (W = write with chipselect=1, write_n=0; R = read with chipselect=1, write_n=1):
  - IDLE: no access.
  - CLR_ST: W addr0 data 0. tick=1, tick_count+1. Return to IDLE. IRQ drops before IDLE re-samples, so exactly one tick per timeout.
  - ST_PL: W addr2 per_q[15:0] -> ST_PH.
  - ST_PH: W addr3 per_q[31:16] -> ST_CTL.
  - ST_CTL: W addr1 data {12'b0, 1'b0, 1'b1, cont_q, 1'b1} (START, CONT, ITO). running=1 at next edge -> IDLE.
  - SP_CTL: W addr1 data 16'h0008 (STOP, ITO off). running=0 at next edge -> IDLE.
  - SN_WR: W addr4 data 0 -> SN_RL.
  - SN_RL: R addr4 -> SN_RH.
  - SN_RH: R addr5; capture m_readdata into snap_value[15:0] -> SN_DN.
  - SN_DN: no access; capture m_readdata into snap_value[31:16]; snap_valid=1 -> IDLE.
- Sequences are atomic: timer_irq is serviced only from IDLE. The worst-case service delay is 4 cycles (snapshot in progress).
- Start while running: full reprogram without a stop write. Writing the period halts the timer and ST_CTL restarts it.
- One-shot mode (cont_q=0): running stays 1 after expiry until a stop. The expiry still yields a tick.
- AUTO_START=1: after reset release, start_p=1 with per_q=DEFAULT_PERIOD and cont_q=1.
- Reset mid-sequence: immediate return to reset values. No partial bus access completes after reset assertion.

Test Plan:
- cfg_period=32'h0001_0004, cont=1, start_req -> W addr2 0x0004, W addr3 0x0001, W addr1 0x0007 on 3 consecutive cycles; running=1 next cycle.
- timer_irq held until the addr0 write -> exactly one tick and tick_count=1; repeated every 0x10005 cycles in a timer model.
- snap_req with model snapshot 0x1234_5678 -> W addr4, R addr4, R addr5; snap_value=0x12345678 with a single snap_valid pulse.
- timer_irq rises while in SN_RL -> snapshot completes first, then CLR_ST; no tick lost or doubled.
- stop_req and start_req in the same cycle while idle -> only W addr1 0x0008; running=0; start discarded.
- reset_n low during ST_PH -> next cycle m_chipselect=0 and running=0; with AUTO_START=1 the default sequence writes 0xF07F then 0x02FA.
